// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: byte width,
// sequencer state encoding and the requester index width helper.
package uart_tx_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STROBE = 2'd1,
        SEQ_GUARD  = 2'd2,
        SEQ_WAIT   = 2'd3
    } seq_state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte streams plus the transmitter strobe/ready handshake.
// The scheduler uses the slave view; the environment uses master.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 2
);
    import uart_tx_sched_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      uart_ready;
    logic [BYTE_W-1:0]         uart_sdata;
    logic                      uart_send_strobe;

    modport master (
        output req_valid, req_data, req_last, uart_ready,
        input  req_ready, uart_sdata, uart_send_strobe
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_ready,
        output req_ready, uart_sdata, uart_send_strobe
    );

endinterface

// File: rtl/uart_tx_sched_fifo.sv
// Synchronous byte FIFO with an occupancy counter; the counter carries
// one extra bit so full and empty stay distinguishable.
module uart_tx_fifo
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [BYTE_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    output logic [BYTE_W-1:0]       rd_data_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       level_q;
    logic              do_wr_s;
    logic              do_rd_s;

    assign empty_o   = (level_q == {(AW+1){1'b0}});
    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_wr_s   = wr_en_i & ~full_o;
    assign do_rd_s   = rd_en_i & ~empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + (AW+1)'(do_wr_s) - (AW+1)'(do_rd_s);
        end
    end

    // Storage array; contents are don't-care while the level says empty.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between several requesters: message-locked
// round-robin arbitration, a byte FIFO and the strobe/ready sequencer.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int FIFO_DEPTH = 8,
    localparam int OW         = idx_width(NUM_REQ),
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_sched_if.slave    tx_if,
    output logic [OW-1:0]     owner_o,
    output logic              locked_o,
    output logic [LW-1:0]     fifo_level_o,
    output logic              busy_o
);

    logic              locked_q, locked_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     last_owner_q, last_owner_d;
    logic              grant_hit_s;
    logic [OW-1:0]     grant_idx_s;
    logic [OW-1:0]     cand_s;
    logic              take_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic              accept_s;
    logic              accept_last_s;
    logic [BYTE_W-1:0] wr_data_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [BYTE_W-1:0] fifo_head_s;
    logic              pop_s;
    seq_state_e        state_q;
    logic              strobe_q;
    logic [BYTE_W-1:0] sdata_q;

    // Round-robin search starting one past the previous message owner.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = {OW{1'b0}};
        cand_s      = {OW{1'b0}};
        take_s      = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s      = OW'((int'(last_owner_q) + k) % NUM_REQ);
            take_s      = ~grant_hit_s & tx_if.req_valid[cand_s];
            grant_idx_s = take_s ? cand_s : grant_idx_s;
            grant_hit_s = grant_hit_s | take_s;
        end
    end

    // Only the lock holder may be ready, and only while the FIFO has room.
    always_comb begin
        req_ready_s          = {NUM_REQ{1'b0}};
        req_ready_s[owner_q] = locked_q & ~fifo_full_s;
    end

    assign accept_s      = locked_q & ~fifo_full_s & tx_if.req_valid[owner_q];
    assign accept_last_s = accept_s & tx_if.req_last[owner_q];
    assign wr_data_s     = tx_if.req_data[BYTE_W*int'(owner_q) +: BYTE_W];

    // Lock is taken on a grant and released by the accepted last byte.
    always_comb begin
        locked_d     = locked_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        if (!locked_q) begin
            if (grant_hit_s) begin
                locked_d = 1'b1;
                owner_d  = grant_idx_s;
            end else begin
                locked_d = 1'b0;
            end
        end else begin
            if (accept_last_s) begin
                locked_d     = 1'b0;
                last_owner_d = owner_q;
            end else begin
                locked_d = 1'b1;
            end
        end
    end

    // Arbiter state; last_owner starts at the top so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q     <= 1'b0;
            owner_q      <= {OW{1'b0}};
            last_owner_q <= OW'(NUM_REQ - 1);
        end else begin
            locked_q     <= locked_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (accept_s),
        .wr_data_i (wr_data_s),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_head_s),
        .empty_o   (fifo_empty_s),
        .full_o    (fifo_full_s),
        .level_o   (fifo_level_o)
    );

    assign pop_s = (state_q == SEQ_STROBE);

    // Sequencer; GUARD hides the transmitter's one-cycle-late ready drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEQ_IDLE;
            strobe_q <= 1'b0;
            sdata_q  <= {BYTE_W{1'b0}};
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (!fifo_empty_s && tx_if.uart_ready) begin
                        state_q  <= SEQ_STROBE;
                        strobe_q <= 1'b1;
                        sdata_q  <= fifo_head_s;
                    end else begin
                        strobe_q <= 1'b0;
                    end
                end
                SEQ_STROBE: begin
                    state_q  <= SEQ_GUARD;
                    strobe_q <= 1'b0;
                end
                SEQ_GUARD: begin
                    state_q  <= SEQ_WAIT;
                    strobe_q <= 1'b0;
                end
                SEQ_WAIT: begin
                    if (tx_if.uart_ready) begin
                        state_q <= SEQ_IDLE;
                    end else begin
                        state_q <= SEQ_WAIT;
                    end
                    strobe_q <= 1'b0;
                end
                default: begin
                    state_q  <= SEQ_IDLE;
                    strobe_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.req_ready        = req_ready_s;
    assign tx_if.uart_send_strobe = strobe_q;
    assign tx_if.uart_sdata       = sdata_q;
    assign owner_o                = owner_q;
    assign locked_o               = locked_q;
    assign busy_o                 = ~fifo_empty_s | (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench: a message-level round-robin model predicts
// the transmitted byte order, a UART model checks every strobe against it.
module tb_uart_tx_sched;

    localparam int NUM_REQ    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int FRAME      = 20;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:0]  owner_o;
    logic        locked_o;
    logic [3:0]  fifo_level_o;
    logic        busy_o;

    uart_tx_sched_if #(.NUM_REQ(NUM_REQ)) tx_if();

    uart_tx_sched #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_if        (tx_if),
        .owner_o      (owner_o),
        .locked_o     (locked_o),
        .fifo_level_o (fifo_level_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    beat_t      rq [NUM_REQ][$];
    logic [7:0] exp_q [$];
    int         rr_last = NUM_REQ - 1;
    bit         drv_en = 1'b0;
    int         gap_max = 0;
    bit         stall = 1'b0;
    int         lag_cyc = 0;
    int         tx_cnt = 0;
    int         strobe_cnt = 0;
    int         in_msg = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic add_beat(input int r, input logic [7:0] d, input bit last);
        beat_t b;
        b.d = d;
        b.last = last;
        rq[r].push_back(b);
    endtask

    task automatic add_msg(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            add_beat(r, 8'($urandom_range(255, 0)), (i == n - 1));
        end
    endtask

    // Message-granular round robin over everything queued at the requesters.
    task automatic model_expect();
        beat_t m [NUM_REQ][$];
        beat_t b;
        int    r;
        bit    more;
        for (int i = 0; i < NUM_REQ; i++) m[i] = rq[i];
        more = 1'b1;
        while (more) begin
            r = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (r < 0 && m[(rr_last + k) % NUM_REQ].size() > 0) r = (rr_last + k) % NUM_REQ;
            end
            if (r < 0) begin
                more = 1'b0;
            end else begin
                do begin
                    b = m[r].pop_front();
                    exp_q.push_back(b.d);
                end while (!b.last);
                rr_last = r;
            end
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += rq[i].size();
        return s;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while ((pending() != 0 || exp_q.size() != 0 || busy_o !== 1'b0 || tx_cnt != 0) && n < max_cyc) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, (n < max_cyc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_level(input string name, input int lvl, input int max_cyc);
        int n = 0;
        while (fifo_level_o < 4'(lvl) && n < max_cyc) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, (n < max_cyc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(tx_if.req_ready), 32'd0);
        check({tag, "_strobe"}, 32'(tx_if.uart_send_strobe), 32'd0);
        check({tag, "_sdata"}, 32'(tx_if.uart_sdata), 32'd0);
        check({tag, "_locked"}, 32'(locked_o), 32'd0);
        check({tag, "_owner"}, 32'(owner_o), 32'd0);
        check({tag, "_level"}, 32'(fifo_level_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    // Requester drivers: hold each byte until accepted, random gaps inside messages.
    initial begin : drivers
        int    gap [NUM_REQ];
        bit    acc [NUM_REQ];
        beat_t b;
        tx_if.req_valid = '0;
        tx_if.req_data  = '0;
        tx_if.req_last  = '0;
        for (int r = 0; r < NUM_REQ; r++) gap[r] = 0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) begin
                acc[r] = (tx_if.req_valid[r] === 1'b1) && (tx_if.req_ready[r] === 1'b1) && !reset;
            end
            @(posedge clk); #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (acc[r] && rq[r].size() > 0) begin
                    b = rq[r].pop_front();
                    gap[r] = b.last ? 0 : int'($urandom_range(gap_max, 0));
                end
                if (gap[r] > 0) begin
                    gap[r]--;
                    tx_if.req_valid[r] = 1'b0;
                end else if (drv_en && rq[r].size() > 0) begin
                    tx_if.req_valid[r]        = 1'b1;
                    tx_if.req_data[8*r +: 8]  = rq[r][0].d;
                    tx_if.req_last[r]         = rq[r][0].last;
                end else begin
                    tx_if.req_valid[r] = 1'b0;
                end
            end
        end
    end

    // Transmitter model and output monitor: legality of each strobe plus data order.
    initial begin : uart_model
        int lag_left = 0;
        bit prev_strobe = 1'b0;
        bit ready_lag = 1'b0;
        tx_if.uart_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_if.uart_send_strobe === 1'b1) begin
                strobe_cnt++;
                check("strobe_legal", (tx_if.uart_ready === 1'b1 && !ready_lag && !prev_strobe) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: sdata %0h while no byte expected", tx_if.uart_sdata);
                end else begin
                    check("sdata", 32'(tx_if.uart_sdata), 32'(exp_q.pop_front()));
                end
                lag_left = lag_cyc;
                tx_cnt   = FRAME;
            end
            prev_strobe = (tx_if.uart_send_strobe === 1'b1);
            if (lag_left > 0) begin
                lag_left--;
                ready_lag = 1'b1;
                tx_if.uart_ready = 1'b1;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                ready_lag = 1'b0;
                tx_if.uart_ready = 1'b0;
            end else begin
                ready_lag = 1'b0;
                tx_if.uart_ready = ~stall;
            end
        end
    end

    // Accept monitor: no other requester may be accepted inside a message.
    initial begin : accept_mon
        forever begin
            @(negedge clk);
            if (reset) begin
                in_msg = -1;
            end else begin
                if (tx_if.req_ready !== '0) begin
                    check("ready_onehot", ($countones(tx_if.req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
                end
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (tx_if.req_valid[r] === 1'b1 && tx_if.req_ready[r] === 1'b1) begin
                        check("lock_hold", (in_msg == -1 || in_msg == r) ? 32'd1 : 32'd0, 32'd1);
                        in_msg = tx_if.req_last[r] ? -1 : r;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int s0;
        int n;
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("rst");
        @(posedge clk); #1;
        reset  = 1'b0;
        drv_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Contention from reset: requester 0 first, then strict alternation.
        gap_max = 2;
        for (int i = 0; i < 3; i++) begin
            add_msg(0, 3);
            add_msg(1, 3);
        end
        model_expect();
        wait_idle("contention_done", 3000);

        // Single short message with fixed bytes.
        gap_max = 0;
        s0 = strobe_cnt;
        add_beat(0, 8'h48, 1'b0);
        add_beat(0, 8'h69, 1'b1);
        model_expect();
        n = 0;
        while (rq[0].size() != 0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("single_accepted", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        check("single_unlock", 32'(locked_o), 32'd0);
        wait_idle("single_done", 500);
        check("single_strobes", 32'(strobe_cnt - s0), 32'd2);

        // FIFO fills behind a stalled transmitter, then drains in order.
        stall = 1'b1;
        add_msg(0, 12);
        model_expect();
        wait_level("fifo_fill", FIFO_DEPTH, 100);
        repeat (3) @(posedge clk);
        #2;
        check("fifo_level_full", 32'(fifo_level_o), 32'(FIFO_DEPTH));
        check("fifo_full_ready", 32'(tx_if.req_ready), 32'd0);
        check("fifo_full_locked", 32'(locked_o), 32'd1);
        check("fifo_full_left", 32'(rq[0].size()), 32'd4);
        check("fifo_full_busy", 32'(busy_o), 32'd1);
        stall = 1'b0;
        wait_idle("fifo_drain_done", 1000);

        // Transmitter whose ready falls one cycle late.
        lag_cyc = 1;
        gap_max = 1;
        add_msg(0, 2);
        add_msg(1, 3);
        add_msg(0, 1);
        model_expect();
        wait_idle("guard_done", 1000);
        lag_cyc = 0;

        // Reset with bytes queued and a message half accepted.
        stall = 1'b1;
        gap_max = 0;
        add_msg(0, 10);
        model_expect();
        wait_level("pre_reset_fill", 5, 100);
        @(posedge clk); #1;
        reset  = 1'b1;
        drv_en = 1'b0;
        @(posedge clk); #2;
        check_reset_values("midrst");
        for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
        exp_q.delete();
        rr_last = NUM_REQ - 1;
        @(posedge clk); #1;
        reset = 1'b0;
        stall = 1'b0;
        s0 = strobe_cnt;
        repeat (60) @(posedge clk);
        #2;
        check("post_reset_silent", 32'(strobe_cnt - s0), 32'd0);
        check("post_reset_level", 32'(fifo_level_o), 32'd0);

        // Fresh traffic after reset: requester 0 wins again.
        drv_en = 1'b1;
        add_msg(1, 2);
        add_msg(0, 2);
        model_expect();
        wait_idle("post_reset_done", 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares the single UART transmitter between several byte-stream requesters (CPU store port, debug/boot monitor). It arbitrates per message using round-robin with a grant lock held until the requester's last byte, buffers granted bytes in a small FIFO, and sequences the transmitter's one-cycle strobe / ready handshake. It sits between the bus-side requesters and the UART transmit core.

## Interface
- NUM_REQ, 2, number of requester ports (2..4)
- FIFO_DEPTH, 8, byte FIFO entries (power of two, ≥2)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a byte
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of requester i's message
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle when valid&ready
- uart_ready  in  1  transmitter idle (high only in its idle state)
- uart_sdata  out  8  byte to transmit; stable whenever uart_send_strobe is high
- uart_send_strobe  out  1  one-cycle start pulse to transmitter
- owner  out  log2(NUM_REQ) (min 1)  index of locked requester; valid when locked=1
- locked  out  1  a message grant is held
- fifo_level  out  log2(FIFO_DEPTH)+1  entries occupied
- busy  out  1  FIFO non-empty or transmitter sequencing in progress

## Operation
- Arbitration: when unlocked, grant the first requester with req_valid=1 searching from (last_owner+1) mod NUM_REQ; last_owner resets to NUM_REQ-1 (so requester 0 wins first). Grant sets locked=1, owner=i on the next edge.
- While locked, only req_ready[owner] may be high; req_ready[owner] = locked & ~fifo_full. All other req_ready are 0.
- Accepted byte with req_last=1 clears locked on the same edge and updates last_owner=owner; arbitration resumes next cycle (one-cycle bubble between messages).
- A requester deasserting valid mid-message keeps the lock; no timeout.
- FIFO: synchronous, write on accept, read when sequencer issues strobe. Simultaneous write and read on full FIFO is not possible (ready low when full); on empty, read is not issued, write lands normally. Pointers wrap modulo FIFO_DEPTH; extra level bit distinguishes full/empty.
- Sequencer FSM:
  - IDLE: if FIFO non-empty and uart_ready=1 → STROBE.
  - STROBE: uart_send_strobe=1, uart_sdata=FIFO head, pop FIFO → GUARD.
  - GUARD: ignore uart_ready for one cycle (transmitter's ready drops one cycle after strobe) → WAIT.
  - WAIT: when uart_ready=1 → IDLE.
- uart_sdata is registered from FIFO head on entering STROBE and held until the next STROBE.
- Reset (any time, including mid-message or mid-byte): FSM→IDLE, FIFO emptied, locked=0, last_owner=NUM_REQ-1. A byte already handed to the transmitter completes on the line; the controller waits in IDLE for uart_ready before the next strobe.

## Timing
- Reset values: req_ready=0, uart_send_strobe=0, uart_sdata=8'h00, locked=0, owner=0, fifo_level=0, busy=0.
- Grant latency: req_valid rises on unlocked idle → locked at edge +1 → req_ready high same cycle locked is high.
- Throughput into FIFO: one byte per cycle while not full.
- Byte to strobe: first byte written at edge t → fifo non-empty t+1 → STROBE state t+2 (strobe asserted cycle after t+1 if uart_ready=1).
- Back-to-back bytes: strobe spacing = transmitter frame time + 2 cycles (IDLE, STROBE overhead); no strobe ever issued while uart_ready=0 or in GUARD.
- uart_send_strobe is never high two consecutive cycles.

## Structure
- Shared package: sequencer state encoding (IDLE, STROBE, GUARD, WAIT), UART byte width constant (8).
- One sub-module: uart_tx_fifo (parameterised synchronous byte FIFO with level output); arbiter and sequencer inline.

## Test plan
- Single message: req0 sends 8'h48,8'h69(last) with uart model (ready low 20 cycles after strobe) → two strobes, sdata 8'h48 then 8'h69, locked drops after 8'h69 accepted.
- Contention: req0 and req1 valid simultaneously from reset, 3-byte messages → req0 message fully queued before any req1 accept; next round req1 wins first.
- Lock hold: req0 drops valid mid-message while req1 valid → req1 never ready until req0 sends last.
- FIFO full: 12-byte message, transmitter stalled → fifo_level reaches 8, req_ready low, no byte lost or duplicated; order preserved on drain.
- Handshake guard: uart_ready held high for 1 cycle after strobe (model lag) → no second strobe until ready falls and rises again.
- Reset mid-message: assert reset with 5 bytes queued → all outputs to reset values next cycle, FIFO empty, no further strobes until new request.
